// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, responder side of enable/ready.
// Latency: XLEN+1 cycles from request capture to ready (1 cycle for divide-by-zero / signed overflow).
// Backpressure: none; initiator holds enable with stable operands, dropping enable while busy aborts.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [3:0]      div_op,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_rem_sel;
    logic            r_negq;
    logic            r_negr;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_result;

    logic [3:0]      w_op;
    logic            w_signed;
    logic            w_rem_sel;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_special;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_qbit;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_dvd_nxt;
    logic [XLEN-1:0] w_rem_out;
    logic [XLEN-1:0] w_final;
    logic            w_last;

    // Zero or multi-hot selects fall back to divu.
    assign w_op      = $onehot(div_op) ? div_op : 4'b0010;
    assign w_signed  = w_op[0] | w_op[2];
    assign w_rem_sel = w_op[2] | w_op[3];
    assign w_div0    = (rdata2 == '0);
    assign w_ovf     = w_signed && (rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (rdata2 == '1);
    assign w_abs1    = (w_signed && rdata1[XLEN-1]) ? -rdata1 : rdata1;
    assign w_abs2    = (w_signed && rdata2[XLEN-1]) ? -rdata2 : rdata2;

    always_comb begin
        w_special = '0;
        if (w_div0) begin
            w_special = w_rem_sel ? rdata1 : '1;
        end else if (!w_rem_sel) begin
            w_special = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One restoring step: dividend shifts into the remainder, quotient bits shift in from the right.
    assign w_shift   = {r_rem[XLEN-1:0], r_dvd[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_trial[XLEN];
    assign w_rem_nxt = w_qbit ? w_trial : w_shift;
    assign w_dvd_nxt = {r_dvd[XLEN-2:0], w_qbit};
    assign w_rem_out = w_rem_nxt[XLEN-1:0];
    assign w_last    = (r_cnt == CW'(1));

    always_comb begin
        w_final = '0;
        if (r_rem_sel) begin
            w_final = r_negr ? -w_rem_out : w_rem_out;
        end else begin
            w_final = r_negq ? -w_dvd_nxt : w_dvd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_rem_sel <= 1'b0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_rem_sel <= w_rem_sel;
                        r_negq    <= w_signed & (rdata1[XLEN-1] ^ rdata2[XLEN-1]) & ~w_div0;
                        r_negr    <= w_signed & rdata1[XLEN-1];
                        r_dvd     <= w_abs1;
                        r_dvs     <= w_abs2;
                        r_rem     <= '0;
                        r_cnt     <= CW'(XLEN);
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                        end
                    end
                end
                S_BUSY: begin
                    if (enable) begin
                        r_dvd <= w_dvd_nxt;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last) begin
                            r_result <= w_final;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, values, special cases, abort, back-to-back and async reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_div_unit;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rdata1 = '0;
    logic [31:0] rdata2 = '0;
    logic [3:0]  div_op = '0;
    logic        ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_unit #(.XLEN(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .div_op (div_op),
        .ready  (ready),
        .result (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Counts cycles until ready; gives up after 80 so a missing ready shows as a latency failure.
    task automatic wait_rdy(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 80) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp, input int lat);
        int n;
        rdata1 = a;
        rdata2 = b;
        div_op = op;
        enable = 1'b1;
        wait_rdy(n);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, result, exp);
        enable = 1'b0;
        step();
        chk({tag, " pulse"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int  n;
        logic seen;

        #12;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset result", result, 32'd0);
        step();
        reset = 1'b1;
        step();

        do_op("divu 100/7",   32'd100, 32'd7, 4'b0010, 32'd14, 33);
        do_op("remu 100/7",   32'd100, 32'd7, 4'b1000, 32'd2,  33);
        do_op("div -7/2",     32'hFFFF_FFF9, 32'd2, 4'b0001, 32'hFFFF_FFFD, 33);
        do_op("rem -7/2",     32'hFFFF_FFF9, 32'd2, 4'b0100, 32'hFFFF_FFFF, 33);
        do_op("rem 7/-2",     32'd7, 32'hFFFF_FFFE, 4'b0100, 32'd1, 33);
        do_op("div -8/-2",    32'hFFFF_FFF8, 32'hFFFF_FFFE, 4'b0001, 32'd4, 33);
        do_op("div min/2",    32'h8000_0000, 32'd2, 4'b0001, 32'hC000_0000, 33);
        do_op("divu big",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0010, 32'd1, 33);
        do_op("remu big",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 32'd1, 33);
        do_op("div ovf",      32'h8000_0000, 32'hFFFF_FFFF, 4'b0001, 32'h8000_0000, 1);
        do_op("rem ovf",      32'h8000_0000, 32'hFFFF_FFFF, 4'b0100, 32'd0, 1);
        do_op("divu 5/0",     32'd5, 32'd0, 4'b0010, 32'hFFFF_FFFF, 1);
        do_op("remu 5/0",     32'd5, 32'd0, 4'b1000, 32'd5, 1);
        do_op("rem -5/0",     32'hFFFF_FFFB, 32'd0, 4'b0100, 32'hFFFF_FFFB, 1);
        do_op("op zero",      32'd100, 32'd7, 4'b0000, 32'd14, 33);
        do_op("op multihot",  32'hFFFF_FFF9, 32'd2, 4'b0101, 32'h7FFF_FFFC, 33);

        // Abort in C5, idle through C7, new request in C8.
        rdata1 = 32'd1000;
        rdata2 = 32'd3;
        div_op = 4'b0010;
        enable = 1'b1;
        seen   = 1'b0;
        repeat (5) begin
            step();
            seen |= ready;
        end
        enable = 1'b0;
        repeat (3) begin
            step();
            seen |= ready;
        end
        chk("abort no ready", 32'(seen), 32'd0);
        rdata1 = 32'd9;
        enable = 1'b1;
        wait_rdy(n);
        chk("after abort latency", 32'(n), 32'd33);
        chk("after abort result", result, 32'd3);
        enable = 1'b0;
        step();

        // Back-to-back with enable held high throughout.
        rdata1 = 32'd100;
        rdata2 = 32'd7;
        div_op = 4'b0010;
        enable = 1'b1;
        wait_rdy(n);
        chk("b2b first latency", 32'(n), 32'd33);
        chk("b2b first result", result, 32'd14);
        step();
        chk("b2b ready width", 32'(ready), 32'd0);
        chk("b2b result hold", result, 32'd14);
        rdata1 = 32'd50;
        rdata2 = 32'd5;
        wait_rdy(n);
        chk("b2b spacing", 32'(n + 1), 32'd34);
        chk("b2b second result", result, 32'd10);
        enable = 1'b0;
        step();

        // Asynchronous reset in C10, then a fresh request on release.
        rdata1 = 32'd1000;
        rdata2 = 32'd3;
        div_op = 4'b0010;
        enable = 1'b1;
        repeat (10) step();
        #2;
        reset = 1'b0;
        #1;
        chk("midop reset ready", 32'(ready), 32'd0);
        chk("midop reset result", result, 32'd0);
        step();
        reset = 1'b1;
        wait_rdy(n);
        chk("post reset latency", 32'(n), 32'd33);
        chk("post reset result", result, 32'd333);
        enable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
